// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver, 8 data bits LSB-first, 1 stop bit.
// Optional even parity bit between data and stop when UART_RX_PARITY_EN is defined.
// Ports: clk, rst (async, active-high), rx (async serial line, idle high),
//   rd_en (consumer read strobe), rx_data/rx_valid (held byte and unread flag),
//   busy (in a frame), frame_err/overrun/parity_err (sticky, cleared by rd_en).
module uart_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic          rx_s1_q;
  logic          rx_s2_q;
  logic          rx_prev_q;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    smp_cnt_q, smp_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;

  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic          tick;
  logic          fall;
  logic          mid_smp;
  logic          end_smp;
  logic          commit;
  logic          ferr_set;

`ifdef UART_RX_PARITY_EN
  logic          par_bit_q, par_bit_d;
  logic          parity_err_q, parity_err_d;
`endif

  // rx is asynchronous; only rx_s2_q is used for decisions.
  // rx_prev_q is the previous synchronized value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign tick    = (tick_cnt_q == TICK_MAX);
  assign fall    = rx_prev_q & ~rx_s2_q;
  assign mid_smp = tick && (smp_cnt_q == 4'd7);
  assign end_smp = tick && (smp_cnt_q == 4'd15);

  // Next state and datapath.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    commit    = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
        end
      end
      S_START: begin
        // Mid-bit check rejects glitches shorter than half a bit.
        if (mid_smp) begin
          bit_cnt_d = 3'd0;
          state_d   = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (end_smp) begin
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (end_smp) begin
          par_bit_d = rx_s2_q;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (end_smp) begin
          commit   = rx_s2_q;
          ferr_set = ~rx_s2_q;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Oversample counters: idle-held, and the sample index realigns
  // to zero on every state change so each bit is counted from its edge.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    if (state_q == S_IDLE) begin
      tick_cnt_d = '0;
      smp_cnt_d  = 4'd0;
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      if (tick) begin
        smp_cnt_d = smp_cnt_q + 4'd1;
      end
    end
    if (state_d != state_q) begin
      smp_cnt_d = 4'd0;
      if (state_d == S_START) begin
        tick_cnt_d = '0;
      end
    end
  end

  // Output holding register and sticky flags. A read clears first,
  // then a same-cycle commit or frame error re-asserts its own bits.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (rd_en) begin
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
    if (commit) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd_en) begin
        overrun_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (^{shift_q, par_bit_q}) begin
        parity_err_d = 1'b1;
      end
`endif
    end
    if (ferr_set) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      smp_cnt_q   <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 Parameter DIV, default CLK_FREQ/(BAUD*16) integer-truncated (54 at defaults), clocks per oversample tick.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 rd_en  input  1  consumer read strobe, one clk per byte taken.
REQ-008 rx_data  output  8  last received byte (uint8).
REQ-009 rx_valid  output  1  rx_data holds an unread byte.
REQ-010 busy  output  1  receiver is in a frame (state not IDLE).
REQ-011 frame_err  output  1  sticky, stop bit sampled low.
REQ-012 overrun  output  1  sticky, unread byte overwritten.
REQ-013 parity_err  output  1  sticky, parity mismatch (see Configuration).

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before use; all decisions use the synchronized value.
REQ-015 Tick counter SHALL count 0..DIV-1 and pulse tick for one clk at DIV-1; it SHALL be held at 0 in IDLE and restart from 0 on entry to START.
REQ-016 A sample counter SHALL count ticks 0..15 within each bit; it SHALL be cleared on every state transition.
REQ-017 States: IDLE, START, DATA, PARITY (only when macro defined), STOP.
REQ-018 IDLE -> START only on a falling edge of synchronized rx (previous 1, current 0); a held-low line SHALL NOT start a frame.
REQ-019 START: on tick 7 (mid-bit), rx=1 -> IDLE with no flag change (glitch rejected); rx=0 -> DATA.
REQ-020 DATA: on tick 15 of each bit, sample rx and shift in LSB-first; after the 8th bit -> PARITY or STOP.
REQ-021 STOP: on tick 15 sample rx; 1 -> commit byte; 0 -> set frame_err, discard byte, rx_valid and rx_data unchanged; both -> IDLE.
REQ-022 Commit: rx_data and rx_valid=1 SHALL update on the clk following the stop-sample tick.
REQ-023 rd_en with rx_valid=1 SHALL clear rx_valid, frame_err, overrun and parity_err next clk; rd_en with rx_valid=0 SHALL clear only the error flags.
REQ-024 Commit while rx_valid=1 and rd_en=0: rx_data overwritten, overrun=1.
REQ-025 Commit and rd_en in same clk: commit wins, rx_valid stays 1, overrun not set, previous flags cleared.
REQ-026 busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 rst=1 SHALL force immediately, independent of clk: state IDLE, counters 0, synchronizer flops 1, shift register 0, rx_data=0x00, rx_valid=0, busy=0, frame_err=0, overrun=0, parity_err=0.
REQ-028 rst asserted mid-frame SHALL abort the frame with no commit; after release a new frame requires a fresh falling edge.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: frame is start, 8 data, even-parity bit, stop; PARITY state samples on tick 15, and on commit parity_err=1 if XOR of data and parity bit is 1 (byte still committed, rx_valid=1).
REQ-030 UART_RX_PARITY_EN undefined: no PARITY state, 10-bit frame, parity_err tied 0.

Verification (defaults, DIV=54, 864 clk per bit)
REQ-031 Send 0xA5, 8N1 -> rx_valid=1 with rx_data=0xA5 ~9.5 bit times after start edge, all error flags 0; rd_en -> rx_valid=0.
REQ-032 rx low for 200 clk then high -> busy pulses, returns to IDLE at mid-start sample, rx_valid=0, flags 0.
REQ-033 Send 0x3C with stop bit 0 -> frame_err=1, rx_valid=0, rx_data=0x00.
REQ-034 Send 0x11 then 0x22 without rd_en -> rx_data=0x22, rx_valid=1, overrun=1; rd_en -> rx_valid=0, overrun=0.
REQ-035 Assert rst in bit 4 of 0x5A, release, send 0x81 -> only 0x81 committed, no flags.
REQ-036 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> rx_data=0x07, rx_valid=1, parity_err=1; with parity bit 1 -> parity_err=0.
